// File: rtl/uart_tx.sv
// UART transmitter: TX FIFO (or single holding register), baud prescaler with
// 16x/13x oversampling, and a framing FSM driving a registered serial line.
module uart_tx #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        apb_clk_in,
    input  logic        apb_rst_in,
    input  logic [7:0]  thr_in,
    input  logic        thr_wr_in,
    input  logic [1:0]  wls_in,
    input  logic        stb_in,
    input  logic        pen_in,
    input  logic        eps_in,
    input  logic        sp_in,
    input  logic        bc_in,
    input  logic [15:0] dlr_in,
    input  logic        osm_in,
    input  logic        fifoen_in,
    input  logic        txclr_in,
    input  logic        utrst_in,
    output logic        txd_out,
    output logic        thre_out,
    output logic        temt_out,
    output logic [4:0]  tx_level_out
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t         state;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count, depth;
    logic           fifoen_q;
    logic           rst, clr, empty, full, push, pop;

    logic [15:0]    presc;
    logic           tick, last_tick;
    logic [5:0]     tick_cnt, tick_last, bit_last, stop_len, stop_last, ovs6;
    logic [2:0]     bit_idx, bit_last_idx;
    logic [7:0]     shreg, head, mask;
    logic [1:0]     wls_q;
    logic           pen_q, stb_q, par_q, par_calc, txd_q;
    logic [4:0]     ovs_q;

    assign rst   = apb_rst_in | ~utrst_in;
    assign clr   = txclr_in | (fifoen_in != fifoen_q);
    assign depth = fifoen_in ? CW'(FIFO_DEPTH) : CW'(1);
    assign empty = (count == '0);
    assign full  = (count >= depth);
    assign head  = mem[rd_ptr];

    assign tick      = (dlr_in != '0) && (presc >= dlr_in - 16'd1);
    assign ovs6      = {1'b0, ovs_q};
    assign bit_last  = ovs6 - 6'd1;
    assign stop_len  = !stb_q ? ovs6 : ((wls_q == 2'd0) ? ovs6 + (ovs6 >> 1) : ovs6 << 1);
    assign stop_last = stop_len - 6'd1;
    assign tick_last = (state == STOP) ? stop_last : bit_last;
    assign last_tick = tick && (tick_cnt == tick_last);
    assign bit_last_idx = {1'b0, wls_q} + 3'd4;

    // Pop either from idle or on the final stop tick, so frames chain without a gap.
    assign pop  = !empty && !clr && (dlr_in != '0) &&
                  ((state == IDLE) || (state == STOP && last_tick));
    assign push = thr_wr_in && !clr && (!full || pop);

    assign mask     = 8'hFF >> (2'd3 - wls_in);
    assign par_calc = sp_in ? ~eps_in : ((^(head & mask)) ^ ~eps_in);

    always_ff @(posedge apb_clk_in) begin
        if (push)
            mem[wr_ptr] <= thr_in;
    end

    always_ff @(posedge apb_clk_in) begin
        fifoen_q <= fifoen_in;
        if (rst || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge apb_clk_in) begin
        if (rst) begin
            state    <= IDLE;
            txd_q    <= 1'b1;
            presc    <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            wls_q    <= '0;
            pen_q    <= 1'b0;
            stb_q    <= 1'b0;
            par_q    <= 1'b0;
            ovs_q    <= 5'd16;
        end else begin
            if (dlr_in != '0)
                presc <= (pop || tick) ? '0 : presc + 16'd1;
            if (pop) begin
                shreg    <= head;
                wls_q    <= wls_in;
                pen_q    <= pen_in;
                stb_q    <= stb_in;
                par_q    <= par_calc;
                ovs_q    <= osm_in ? 5'd13 : 5'd16;
                tick_cnt <= '0;
                bit_idx  <= '0;
                txd_q    <= 1'b0;
                state    <= START;
            end else if (tick && state != IDLE) begin
                if (!last_tick) begin
                    tick_cnt <= tick_cnt + 6'd1;
                end else begin
                    tick_cnt <= '0;
                    unique case (state)
                        START: begin
                            state <= DATA;
                            txd_q <= shreg[0];
                        end
                        DATA: begin
                            if (bit_idx == bit_last_idx) begin
                                state <= pen_q ? PARITY : STOP;
                                txd_q <= pen_q ? par_q : 1'b1;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                shreg   <= shreg >> 1;
                                txd_q   <= shreg[1];
                            end
                        end
                        PARITY: begin
                            state <= STOP;
                            txd_q <= 1'b1;
                        end
                        default: begin
                            state <= IDLE;
                            txd_q <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign txd_out      = txd_q & ~bc_in;
    assign thre_out     = empty;
    assign temt_out     = empty && (state == IDLE);
    assign tx_level_out = 5'(count);

endmodule
